// File: rtl/rf_wb_arbiter.sv
// Register file writeback arbiter.
// Shares the single register file write port between requester A (ALU results)
// and requester B (load results). A has fixed priority, but B is forced ahead
// once it has stalled MAX_WAIT consecutive cycles. The write command is
// registered, so it reaches the register file one cycle after the handshake.
// Writes to x0 complete their handshake but never assert RegWrite.
// MAX_WAIT must lie in 1..15 to fit the 4-bit wait counter.

module rf_wb_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned MAX_WAIT   = 3
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_rd,
    input  logic [WIDTH-1:0]      a_data,
    output logic                  a_ready,

    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_rd,
    input  logic [WIDTH-1:0]      b_data,
    output logic                  b_ready,

    output logic                  RegWrite,
    output logic [ADDR_WIDTH-1:0] as3,
    output logic [WIDTH-1:0]      WD,
    output logic                  b_starved
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);
    localparam logic [3:0] CntMax  = 4'hF;

    logic                  a_xfer;
    logic                  b_xfer;

    logic [3:0]            wait_cnt_q;
    logic [3:0]            wait_cnt_d;
    logic                  starved_q;
    logic                  starved_d;

    logic                  wr_en_q;
    logic                  wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [WIDTH-1:0]      wr_data_q;
    logic [WIDTH-1:0]      wr_data_d;

    // Grant: A first unless B is being forced; nothing is granted during reset.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            if (starved_q) begin
                b_ready = b_valid;
            end else begin
                a_ready = a_valid;
                b_ready = b_valid && !a_valid;
            end
        end
    end

    assign a_xfer = a_valid && a_ready;
    assign b_xfer = b_valid && b_ready;

    // Starvation tracking: count consecutive stalled B cycles, force B at MAX_WAIT.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        starved_d  = starved_q;
        if (starved_q) begin
            // Forced mode ends with B's transfer (or B going idle); restart counting.
            if (b_xfer || !b_valid) begin
                starved_d  = 1'b0;
                wait_cnt_d = 4'd0;
            end
        end else if (b_xfer || !b_valid) begin
            wait_cnt_d = 4'd0;
        end else begin
            // B is valid and was refused this cycle.
            if (wait_cnt_q != CntMax) begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
            starved_d = (wait_cnt_d >= MaxWait);
        end
    end

    // Next write command: the winner's address/data, enable suppressed for x0.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (a_xfer) begin
            wr_en_d   = (a_rd != '0);
            wr_addr_d = a_rd;
            wr_data_d = a_data;
        end else if (b_xfer) begin
            wr_en_d   = (b_rd != '0);
            wr_addr_d = b_rd;
            wr_data_d = b_data;
        end
    end

    // State update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 4'd0;
            starved_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            starved_q  <= starved_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign RegWrite  = wr_en_q;
    assign as3       = wr_addr_q;
    assign WD        = wr_data_q;
    assign b_starved = starved_q;

endmodule
